// File: rtl/uart_cmd_sequencer.sv
// Framed UART command parser driving the matrix/vector processor load side.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_sequencer #(
   parameter int N_RESET        = 3,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       full_A,
   output logic [7:0] data_out,
   output logic       push_A,
   output logic       push_B,
   output logic [3:0] N,
   output logic       clear,
   output logic       cmd_done,
   output logic       cmd_error
);
   // state   | meaning
   // IDLE    | waiting for 0xFE start byte
   // LEN     | next byte is the length L
   // CMD     | next byte is the opcode, checked against L
   // PAYLOAD | consuming L-1 payload bytes
   // END     | expecting the 0xEF terminator
   // SKIP    | rejected frame, discarding up to 0xEF
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LEN     = 3'd1,
      CMD     = 3'd2,
      PAYLOAD = 3'd3,
      END     = 3'd4,
      SKIP    = 3'd5
   } state_t;

   localparam logic [7:0] SOF      = 8'hFE;
   localparam logic [7:0] EOF      = 8'hEF;
   localparam logic [7:0] OP_SET_N = 8'h01;
   localparam logic [7:0] OP_MAT   = 8'h04;
   localparam logic [7:0] OP_VEC   = 8'h05;
   localparam logic [7:0] OP_CLR   = 8'h06;

   state_t     state;
   logic [7:0] len;
   logic [7:0] opcode;
   logic [6:0] remaining;
   logic [3:0] n_new;
   logic       frame_bad;
   logic [7:0] n8;
   logic [7:0] len_mat;
   logic [7:0] len_vec;
   logic       timeout_hit;

   assign n8      = {4'd0, N};
   assign len_mat = n8 * n8 + 8'd1;
   assign len_vec = n8 + 8'd1;

`ifdef CMD_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0] to_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         to_cnt <= '0;
      else if (rx_valid || state == IDLE)
         to_cnt <= '0;
      else if (!timeout_hit)
         to_cnt <= to_cnt + CW'(1);
   end

   assign timeout_hit = (state != IDLE) && !rx_valid && (to_cnt == TO_LAST);
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         len       <= '0;
         opcode    <= '0;
         remaining <= '0;
         n_new     <= '0;
         frame_bad <= 1'b0;
         data_out  <= '0;
         push_A    <= 1'b0;
         push_B    <= 1'b0;
         N         <= 4'(N_RESET);
         clear     <= 1'b0;
         cmd_done  <= 1'b0;
         cmd_error <= 1'b0;
      end else begin
         push_A    <= 1'b0;
         push_B    <= 1'b0;
         clear     <= 1'b0;
         cmd_done  <= 1'b0;
         cmd_error <= 1'b0;
         if (timeout_hit) begin
            state     <= IDLE;
            cmd_error <= 1'b1;
         end else if (rx_valid) begin
            unique case (state)
               IDLE: if (rx_data == SOF) state <= LEN;
               LEN: begin
                  len   <= rx_data;
                  state <= CMD;
               end
               CMD: begin
                  opcode    <= rx_data;
                  frame_bad <= 1'b0;
                  remaining <= len[6:0] - 7'd1;
                  if ((rx_data == OP_SET_N && len == 8'd2) ||
                      (rx_data == OP_MAT && len == len_mat) ||
                      (rx_data == OP_VEC && len == len_vec))
                     state <= PAYLOAD;
                  else if (rx_data == OP_CLR && len == 8'd1)
                     state <= END;
                  else
                     state <= SKIP;
               end
               PAYLOAD: begin
                  remaining <= remaining - 7'd1;
                  if (remaining == 7'd1) state <= END;
                  case (opcode)
                     OP_MAT: begin
                        // a byte refused by a full FIFO poisons the whole frame
                        if (full_A) begin
                           frame_bad <= 1'b1;
                        end else begin
                           push_A   <= 1'b1;
                           data_out <= rx_data;
                        end
                     end
                     OP_VEC: begin
                        push_B   <= 1'b1;
                        data_out <= rx_data;
                     end
                     default: begin
                        if (rx_data >= 8'd2 && rx_data <= 8'd8)
                           n_new <= rx_data[3:0];
                        else
                           frame_bad <= 1'b1;
                     end
                  endcase
               end
               END: begin
                  state <= IDLE;
                  if (rx_data == EOF && !frame_bad) begin
                     cmd_done <= 1'b1;
                     if (opcode == OP_SET_N) N <= n_new;
                     if (opcode == OP_CLR) clear <= 1'b1;
                  end else begin
                     cmd_error <= 1'b1;
                  end
               end
               SKIP: begin
                  if (rx_data == EOF) begin
                     state     <= IDLE;
                     cmd_error <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Byte-level command decoder and sequencer for the matrix-vector processor datapath. Consumes received UART bytes, parses framed commands, and drives the processor top's load side: matrix/vector FIFO pushes, shared byte bus, size N, and clear. Sits between the UART receiver and the processor top; it owns the protocol, the top owns the arithmetic.

## Interface
- N_RESET, 3: value of `N` after reset. Legal range 2..8.
- TIMEOUT_CYCLES, 1_000_000: inter-byte timeout. Used only with `CMD_TIMEOUT_EN`.
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  received UART byte; valid only while `rx_valid`=1.
- rx_valid  in  1  one-cycle strobe per received byte; may be asserted back-to-back.
- full_A  in  1  matrix FIFO full, from the processor top.
- data_out  out  8  byte bus to the top's `uart` input.
- push_A  out  1  one-cycle matrix FIFO push.
- push_B  out  1  one-cycle vector FIFO push.
- N  out  4  matrix/vector size (nibble_t).
- clear  out  1  one-cycle clear pulse.
- cmd_done  out  1  one-cycle pulse: frame accepted.
- cmd_error  out  1  one-cycle pulse: frame rejected.

## Operation
- Frame: 0xFE, L, CMD, payload (L-1 bytes), 0xEF. L counts CMD plus payload.
- Commands and required L (N = current register value):
  - 0x01 set N: L=2; payload byte must be 2..8.
  - 0x04 matrix: L=1+N*N; each payload byte is pushed to the matrix FIFO.
  - 0x05 vector: L=1+N; each payload byte is pushed to the vector FIFO.
  - 0x06 clear: L=1.
- L is 8 bits wide; expected length is computed as 8-bit 1+N*N (max 65). No overflow is possible.
- States:
  - IDLE: 0xFE -> LEN; other bytes ignored.
  - LEN: latch L -> CMD.
  - CMD: if opcode is known and L matches -> PAYLOAD, or END when L=1. Otherwise -> SKIP.
  - PAYLOAD: decrement the 7-bit remaining count; at 0 -> END.
  - END: 0xEF -> commit, pulse `cmd_done`, go to IDLE. Any other byte -> pulse `cmd_error`, go to IDLE.
  - SKIP: discard bytes until 0xEF, then pulse `cmd_error` and go to IDLE.
- Commit actions:
  - 0x01 loads N, but only if the payload was 2..8. An out-of-range payload gives `cmd_error` at END and N is unchanged.
  - 0x06 pulses `clear`.
- Payload pushes for 0x04/0x05 are issued immediately, not deferred to END. A bad end byte flags `cmd_error` but does not retract pushes already issued.
- Matrix byte while `full_A`=1: the byte is dropped, no push, and the frame is forced to end in `cmd_error`.
- Outputs in SKIP: no pushes, no `clear`, no N change.
- N changes only at commit. A 0x04/0x05 frame sizes against N as sampled in CMD state.

## Timing
- All outputs are registered. Reset values: `data_out`=0, `push_A`=`push_B`=`clear`=`cmd_done`=`cmd_error`=0, `N`=N_RESET, state IDLE.
- Push latency: `rx_valid` at cycle t gives `push_A`/`push_B` and `data_out`=that byte at t+1, for one cycle.
- Back-to-back `rx_valid` gives back-to-back pushes.
- Commit latency: 0xEF at cycle t gives `cmd_done` (and `clear` or the N update) at t+1.
- `cmd_error` also asserts at t+1 after the offending terminating byte.
- 0xFE seen mid-frame is treated as data; there is no resync except via SKIP/END or timeout.
- Reset asserted mid-frame: immediate return to IDLE and all outputs to reset values. Partially pushed FIFO data is the top's concern.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A counter restarts on every `rx_valid` while outside IDLE.
  - Reaching TIMEOUT_CYCLES-1 with no byte returns the FSM to IDLE and pulses `cmd_error` once.
- `CMD_TIMEOUT_EN` undefined: no counter, and the FSM waits indefinitely. TIMEOUT_CYCLES is unused.

## Test plan
- FE 02 01 04 EF -> `cmd_done` one cycle after EF; N=4. No push, no `clear`.
- N=2, frame FE 05 04 11 22 33 44 EF back-to-back -> four `push_A` pulses, `data_out`=11,22,33,44 on consecutive cycles, then `cmd_done`.
- N=3, FE 03 05 AA BB EF (L should be 4) -> no `push_B`, `cmd_error` one cycle after EF, N unchanged.
- FE 02 01 09 EF -> `cmd_error`, N stays at previous value. Then FE 01 06 EF -> `clear` and `cmd_done` pulse together.
- N=2, `full_A`=1 during the 2nd matrix byte -> 3 pushes only, `cmd_error` at EF. Assert `rst` low mid-frame -> outputs at reset values, next FE frame parsed normally.
- With `CMD_TIMEOUT_EN`, TIMEOUT_CYCLES=16, send FE 02 then stall -> `cmd_error` after 16 idle cycles. The following FE 01 06 EF succeeds.
